// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the framed UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: parity mode constants, receiver state enum, 3-input majority helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK
  } rx_state_e;

  // Majority of three line samples; one corrupted sample cannot flip the bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// uart_rx_framed_if: received-word delivery bundle between receiver and consumer.
// Latency: n/a (wires only).
// Backpressure: word held while dout_valid && !dout_ready.
// Signals: dout, dout_valid, parity_err, frame_err (receiver -> consumer),
//          dout_ready (consumer -> receiver).
interface uart_rx_framed_if #(
  parameter int D_BIT = 8
);

  logic [D_BIT-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             parity_err;
  logic             frame_err;

  modport master (
    output dout,
    output dout_valid,
    output parity_err,
    output frame_err,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  parity_err,
    input  frame_err,
    output dout_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clk.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronised output).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampled UART receiver with majority vote, parity/frame/overrun checks.
// Latency: dout_valid rises 1 clk after the s_tick carrying the final stop-bit vote.
// Backpressure: one-entry buffer; a frame finishing while the buffer is full is dropped
//               and overrun_err pulses for one clk.
// Ports: clk, rst_n, rx (async serial line), s_tick (oversample strobe),
//        out_if (dout/dout_valid/dout_ready/parity_err/frame_err), overrun_err, busy.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int D_BIT     = 8,
  parameter int OS        = 16,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic                 overrun_err,
  output logic                 busy,
  uart_rx_framed_if.master     out_if
);

  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(D_BIT + 1);

  logic             rxs;
  rx_state_e        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [D_BIT-1:0] sh_q, sh_d;
  logic [1:0]       hist_q, hist_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             frame_done;

  logic [D_BIT-1:0] dout_q;
  logic             vld_q, pe_q, fe_q, ovr_q;

  logic             vote;
  logic             s_end;
  logic             stop_err;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxs)
  );

  // hist_q holds the two previous tick samples; the current rxs is the third.
  assign vote     = maj3(hist_q[1], hist_q[0], rxs);
  assign s_end    = (s_q == SW'(OS - 1));
  assign stop_err = ferr_q | ~vote;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      hist_q  <= 2'b11;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      hist_q  <= hist_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    hist_d     = s_tick ? {hist_q[0], rxs} : hist_q;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(OS / 2 - 1)) begin
            // Line back high at mid start bit: treat as noise.
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_end) begin
            s_d  = '0;
            sh_d = {vote, sh_q[D_BIT-1:1]};
            if (n_q == NW'(D_BIT - 1)) begin
              n_d     = '0;
              state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_end) begin
            perr_d  = ((^sh_q) ^ vote) != (PARITY == PARITY_ODD);
            s_d     = '0;
            n_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_end) begin
            s_d    = '0;
            ferr_d = stop_err;
            if (STOP_BITS == 2 && n_q == '0) begin
              n_d = NW'(1);
            end else begin
              n_d        = '0;
              frame_done = 1'b1;
              // A low stop bit may be the start of a break; wait for the line to recover.
              state_d    = stop_err ? BRK : IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      BRK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  // One-entry output buffer; a buffered word is only replaced if consumed this clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (frame_done) begin
        if (!vld_q || out_if.dout_ready) begin
          dout_q <= sh_q;
          pe_q   <= perr_q;
          fe_q   <= stop_err;
          vld_q  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (vld_q && out_if.dout_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = vld_q;
  assign out_if.parity_err = pe_q;
  assign out_if.frame_err  = fe_q;
  assign overrun_err       = ovr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed bench for uart_rx_framed with a per-receiver scoreboard.
// Two receivers: dut_a (8N1) and dut_b (8E1); OS=16, s_tick every 4 clk.
// Expected words are queued as frames are sent and checked when the consumer accepts them.
module tb_uart_rx_framed;
  import uart_pkg::*;

  localparam int BIT = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tick = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic ovr_a, busy_a, ovr_b, busy_b;

  uart_rx_framed_if #(.D_BIT(8)) if_a ();
  uart_rx_framed_if #(.D_BIT(8)) if_b ();

  uart_rx_framed #(.D_BIT(8), .OS(16), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx_a),
    .s_tick      (s_tick),
    .overrun_err (ovr_a),
    .busy        (busy_a),
    .out_if      (if_a)
  );

  uart_rx_framed #(.D_BIT(8), .OS(16), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx_b),
    .s_tick      (s_tick),
    .overrun_err (ovr_b),
    .busy        (busy_b),
    .out_if      (if_b)
  );

  always #5 clk = ~clk;

  int   tc;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_chk = 0;
  int   n_fail = 0;
  int   vld_cyc_a = 0;
  int   acc_a = 0;
  int   acc_b = 0;
  int   ovr_cnt_a = 0;
  int   b0, b1;
  logic [7:0] part;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int line, input logic v);
    if (line == 0) rx_a = v;
    else rx_b = v;
  endtask

  // par < 0: no parity bit; glitch_bit >= 0: one-tick inverted pulse near that bit's middle.
  task automatic send(input int line, input logic [7:0] d, input int par, input int glitch_bit);
    drive(line, 1'b0);
    clk_wait(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(line, d[i]);
      if (i == glitch_bit) begin
        clk_wait(30);
        drive(line, ~d[i]);
        clk_wait(4);
        drive(line, d[i]);
        clk_wait(BIT - 34);
      end else begin
        clk_wait(BIT);
      end
    end
    if (par >= 0) begin
      drive(line, par[0]);
      clk_wait(BIT);
    end
    drive(line, 1'b1);
    clk_wait(BIT);
    clk_wait(16);
  endtask

  initial begin
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  // Consumer-side monitors: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_a.dout_valid) vld_cyc_a++;
      if (ovr_a) ovr_cnt_a++;
      if (if_a.dout_valid && if_a.dout_ready) begin
        acc_a++;
        if (q_a.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL a_extra_frame: observed dout 0x%0h, no word expected", if_a.dout);
        end else begin
          ea = q_a.pop_front();
          chk("a_dout", 32'(if_a.dout), 32'(ea.d));
          chk("a_parity_err", 32'(if_a.parity_err), 32'(ea.pe));
          chk("a_frame_err", 32'(if_a.frame_err), 32'(ea.fe));
        end
      end
      if (if_b.dout_valid && if_b.dout_ready) begin
        acc_b++;
        if (q_b.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL b_extra_frame: observed dout 0x%0h, no word expected", if_b.dout);
        end else begin
          eb = q_b.pop_front();
          chk("b_dout", 32'(if_b.dout), 32'(eb.d));
          chk("b_parity_err", 32'(if_b.parity_err), 32'(eb.pe));
          chk("b_frame_err", 32'(if_b.frame_err), 32'(eb.fe));
        end
      end
    end
  end

  initial begin
    if_a.dout_ready = 1'b1;
    if_b.dout_ready = 1'b1;
    rst_n = 1'b0;
    clk_wait(5);

    // Reset values
    chk("rst_dout", 32'(if_a.dout), 32'd0);
    chk("rst_valid", 32'(if_a.dout_valid), 32'd0);
    chk("rst_parity_err", 32'(if_a.parity_err), 32'd0);
    chk("rst_frame_err", 32'(if_a.frame_err), 32'd0);
    chk("rst_overrun", 32'(ovr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    clk_wait(20);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // 8N1 0xA5, ready high: single valid cycle
    b0 = vld_cyc_a;
    b1 = acc_a;
    q_a.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send(0, 8'hA5, -1, -1);
    chk("a5_valid_cycles", 32'(vld_cyc_a - b0), 32'd1);
    chk("a5_accepts", 32'(acc_a - b1), 32'd1);

    // Even parity, 0x07: wrong parity bit then correct one
    q_b.push_back('{d: 8'h07, pe: 1'b1, fe: 1'b0});
    send(1, 8'h07, 0, -1);
    q_b.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
    send(1, 8'h07, 1, -1);
    chk("par_accepts", 32'(acc_b), 32'd2);

    // False start: low for 6 ticks
    b0 = vld_cyc_a;
    drive(0, 1'b0);
    clk_wait(8);
    chk("false_start_busy_high", 32'(busy_a), 32'd1);
    clk_wait(16);
    drive(0, 1'b1);
    clk_wait(BIT);
    chk("false_start_busy_low", 32'(busy_a), 32'd0);
    chk("false_start_no_valid", 32'(vld_cyc_a - b0), 32'd0);

    // Break: 20 bit times low gives exactly one framed-error word
    b0 = vld_cyc_a;
    b1 = acc_a;
    q_a.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    drive(0, 1'b0);
    clk_wait(20 * BIT);
    chk("break_one_frame", 32'(vld_cyc_a - b0), 32'd1);
    chk("break_busy_held", 32'(busy_a), 32'd1);
    drive(0, 1'b1);
    clk_wait(16);
    chk("break_release_idle", 32'(busy_a), 32'd0);
    q_a.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send(0, 8'h3C, -1, -1);
    chk("break_recover_accepts", 32'(acc_a - b1), 32'd2);

    // Overrun: consumer stalled across two frames
    if_a.dout_ready = 1'b0;
    b0 = ovr_cnt_a;
    q_a.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(0, 8'h11, -1, -1);
    send(0, 8'h22, -1, -1);
    chk("ovr_dout_held", 32'(if_a.dout), 32'h11);
    chk("ovr_valid_held", 32'(if_a.dout_valid), 32'd1);
    chk("ovr_pulses", 32'(ovr_cnt_a - b0), 32'd1);
    if_a.dout_ready = 1'b1;
    clk_wait(2);
    chk("ovr_valid_drop", 32'(if_a.dout_valid), 32'd0);
    chk("ovr_queue_empty", 32'(q_a.size()), 32'd0);

    // Single-tick glitch at bit 3 midpoint
    q_a.push_back('{d: 8'hFF, pe: 1'b0, fe: 1'b0});
    send(0, 8'hFF, -1, 3);
    chk("glitch_queue_empty", 32'(q_a.size()), 32'd0);

    // Reset mid-byte: partial frame discarded
    b1 = acc_a;
    part = 8'h5A;
    drive(0, 1'b0);
    clk_wait(BIT);
    for (int i = 0; i < 4; i++) begin
      drive(0, part[i]);
      clk_wait(BIT);
    end
    chk("midrst_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("midrst_dout", 32'(if_a.dout), 32'd0);
    chk("midrst_valid", 32'(if_a.dout_valid), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_frame_err", 32'(if_a.frame_err), 32'd0);
    drive(0, 1'b1);
    clk_wait(4);
    rst_n = 1'b1;
    clk_wait(10 * BIT);
    chk("midrst_no_frame", 32'(acc_a - b1), 32'd0);
    chk("midrst_idle", 32'(busy_a), 32'd0);

    chk("final_queue_a", 32'(q_a.size()), 32'd0);
    chk("final_queue_b", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
